program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Writer side of the instruction-memory load port consumed by InstructionFetch.
//  Assembles 32-bit instructions from a byte stream (UART receiver: rx_data/rx_done).
//  Drives loadProgram, addressInstrucctionProgram, data_instruction and wr_instruction
//  so the program is written at consecutive word addresses starting at 0.
//  Ends on a HALT word or at memory depth, then releases loadProgram and flags done.
// PARAMETERS
//  MEM_DEPTH   256            instruction-memory depth in words; max words accepted
//  HALT_WORD   32'hFFFFFFFF   end-of-program marker; written, then load ends
// PORTS
//  clk                          in   1   system clock, all state on posedge
//  rst                          in   1   asynchronous, active-high reset
//  start_load                   in   1   1-cycle pulse: begin a new load (ignored in LOAD)
//  rx_data                      in   8   received byte, valid when rx_done=1
//  rx_done                      in   1   1-cycle strobe per received byte
//  loadProgram                  out  1   high for the whole load; muxes IF address to loader
//  addressInstrucctionProgram   out  32  word address of the current write
//  data_instruction             out  32  assembled instruction word
//  wr_instruction               out  1   1-cycle write strobe to instruction memory
//  load_done                    out  1   high from end of load until next start_load
//  load_error                   out  1   high if MEM_DEPTH reached without HALT_WORD
//  instr_count                  out  32  words written in the last/current load
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; byte counter 0; address 0.
//  FSM states: IDLE, LOAD, WRITE, DONE.
//  IDLE: start_load -> LOAD; clear address, instr_count, byte counter, load_done, load_error.
//  DONE: load_done=1; start_load -> LOAD (same clears). rx_done ignored in IDLE/DONE.
//  loadProgram=1 in LOAD and WRITE only (registered; rises the cycle after start_load).
//  LOAD: on rx_done, shift byte into data_instruction, MSB first:
//   data <= {data[23:0], rx_data}; byte counter 0..3 (2-bit, wraps).
//   4th byte (counter==3) -> WRITE next cycle; counter wraps to 0.
//  WRITE (exactly 1 cycle): wr_instruction=1; address and data held stable
//   this cycle and the next, so memory may sample on either clock edge.
//   Exit WRITE: instr_count+1; if data==HALT_WORD -> DONE (address not advanced).
//   Else if address==MEM_DEPTH-1 -> DONE with load_error=1.
//   Else address+1 -> LOAD.
//  rx_done arriving in WRITE: byte accepted as byte 0 of next word (no loss).
//  Partial word (<4 bytes) never written; stays pending until completed.
//  start_load while in LOAD/WRITE: ignored. rst mid-load: immediate return to
//   reset values; loadProgram drops asynchronously; partial word discarded.
//  wr_instruction never asserted outside WRITE; never two consecutive cycles.
//  Address width: internal counter clog2(MEM_DEPTH) bits, zero-extended to 32.
// STRUCTURE
//  Shared package/header: state encodings (ST_IDLE..ST_DONE, 2-bit), HALT_WORD
//   default, MEM_DEPTH default shared with InstructionMemory.
//  One natural sub-module: word_assembler (byte shift register + 2-bit counter,
//   outputs word and word_valid pulse); FSM and address logic in this module.
// TESTING
//  Reset mid-load after 2 bytes -> all outputs 0, next start_load writes addr 0.
//  start_load; bytes 12 34 56 78 -> one wr_instruction, addr 0, data 32'h12345678.
//  3 words then FF FF FF FF -> writes at addr 0..3, 4th data FFFFFFFF, load_done=1,
//   instr_count=4, load_error=0, loadProgram=0.
//  MEM_DEPTH=4, 4 non-HALT words -> 4 writes, load_done=1, load_error=1,
//   further rx_done bytes produce no writes.
//  rx_done in the WRITE cycle (byte AA) then BB CC DD -> next word AABBCCDD at addr+1.
//  start_load during LOAD -> ignored; rx_done while IDLE/DONE -> no write, no state change.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM encodings,
// default memory depth and end-of-program marker.
package program_loader_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int          MEM_DEPTH_DEF = 256;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    // Word-address counter width; a depth of 1 still needs one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if;
    logic        start_load;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        loadProgram;
    logic [31:0] addressInstrucctionProgram;
    logic [31:0] data_instruction;
    logic        wr_instruction;
    logic        load_done;
    logic        load_error;
    logic [31:0] instr_count;

    modport master (
        output start_load, rx_data, rx_done,
        input  loadProgram, addressInstrucctionProgram, data_instruction,
               wr_instruction, load_done, load_error, instr_count
    );
    modport slave (
        input  start_load, rx_data, rx_done,
        output loadProgram, addressInstrucctionProgram, data_instruction,
               wr_instruction, load_done, load_error, instr_count
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs four received bytes MSB-first into a 32-bit word; o_word_valid marks
// the cycle in which the fourth byte arrives, with o_word already complete.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);
    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_en) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_en && (r_cnt == 2'd3);
endmodule

// File: rtl/program_loader.sv
// Loads a program from a UART byte stream into instruction memory at word
// addresses 0,1,2,... until a HALT word or the last memory word is written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          MEM_DEPTH = MEM_DEPTH_DEF,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus
);
    localparam int AW = addr_w(MEM_DEPTH);

    logic [1:0]    r_state;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_data;
    logic [31:0]   r_count;
    logic          r_err;

    logic          w_idle;
    logic          w_accept;
    logic          w_valid;
    logic [31:0]   w_word;

    assign w_idle   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    // Bytes arriving during the write cycle already belong to the next word.
    assign w_accept = bus.rx_done && ((r_state == ST_LOAD) || (r_state == ST_WRITE));

    word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_idle && bus.start_load),
        .i_en         (w_accept),
        .i_byte       (bus.rx_data),
        .o_word       (w_word),
        .o_word_valid (w_valid)
    );

    // Address and data only move on entry to WRITE, so both stay stable through
    // the write cycle and the one after; the next address equals words written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start_load) begin
                        r_state <= ST_LOAD;
                        r_addr  <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_valid) begin
                        r_state <= ST_WRITE;
                        r_data  <= w_word;
                        r_addr  <= r_count[AW-1:0];
                    end
                end
                ST_WRITE: begin
                    r_count <= r_count + 32'd1;
                    if (r_data == HALT_WORD) begin
                        r_state <= ST_DONE;
                    end else if (r_addr == AW'(MEM_DEPTH - 1)) begin
                        r_state <= ST_DONE;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.loadProgram                = (r_state == ST_LOAD) || (r_state == ST_WRITE);
    assign bus.wr_instruction             = (r_state == ST_WRITE);
    assign bus.addressInstrucctionProgram = 32'(r_addr);
    assign bus.data_instruction           = r_data;
    assign bus.load_done                  = (r_state == ST_DONE);
    assign bus.load_error                 = r_err;
    assign bus.instr_count                = r_count;
endmodule

// File: tb/tb_program_loader.sv
// Drives two loaders (depth 256 and depth 4) with the same byte stream and
// checks both against a behavioural model every cycle, plus literal pins.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       st;
    logic       rxd;
    logic [7:0] rxb;

    always #5 clk = ~clk;

    program_loader_if bus0();
    program_loader_if bus1();

    assign bus0.start_load = st;
    assign bus0.rx_done    = rxd;
    assign bus0.rx_data    = rxb;
    assign bus1.start_load = st;
    assign bus1.rx_done    = rxd;
    assign bus1.rx_data    = rxb;

    program_loader #(.MEM_DEPTH(256), .HALT_WORD(32'hFFFF_FFFF)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    program_loader #(.MEM_DEPTH(4), .HALT_WORD(32'hFFFF_FFFF)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: a load collects bytes four at a time; each complete word
    // is written one cycle later at address = words already written.
    int          depth [2] = '{256, 4};
    logic        m_busy[2], m_wr[2], m_done[2], m_err[2];
    int          m_nb[2], m_addr[2], m_count[2];
    logic [31:0] m_acc[2], m_word[2];

    function automatic void model_reset(input int i);
        m_busy[i] = 0; m_wr[i] = 0; m_done[i] = 0; m_err[i] = 0;
        m_nb[i] = 0; m_addr[i] = 0; m_count[i] = 0; m_acc[i] = 0; m_word[i] = 0;
    endfunction

    function automatic void model_step(input int i);
        logic was_busy;
        if (rst) begin
            model_reset(i);
            return;
        end
        was_busy = m_busy[i];
        if (!was_busy) begin
            if (st) begin
                m_busy[i] = 1; m_done[i] = 0; m_err[i] = 0;
                m_addr[i] = 0; m_count[i] = 0; m_nb[i] = 0; m_acc[i] = 0;
            end
            return;
        end
        if (m_wr[i]) begin
            m_wr[i] = 0;
            m_count[i]++;
            if (m_word[i] == 32'hFFFF_FFFF) begin
                m_busy[i] = 0; m_done[i] = 1;
            end else if (m_addr[i] == depth[i] - 1) begin
                m_busy[i] = 0; m_done[i] = 1; m_err[i] = 1;
            end
        end
        if (rxd) begin
            m_acc[i] = {m_acc[i][23:0], rxb};
            m_nb[i]++;
            if (m_nb[i] == 4) begin
                m_nb[i]   = 0;
                m_word[i] = m_acc[i];
                m_addr[i] = m_count[i];
                m_wr[i]   = 1;
            end
        end
    endfunction

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or posedge rst);
            model_step(0);
            model_step(1);
        end
    end

    // Write log of each DUT, used by the literal pins.
    logic [31:0] wa0[$], wd0[$];
    int          wcnt1 = 0;

    function automatic void cmp_dut(input int i, input logic lp, input logic wr, input logic dn,
                                    input logic er, input logic [31:0] ad, input logic [31:0] da,
                                    input logic [31:0] cn);
        chk($sformatf("d%0d_loadProgram", i), 32'(lp), 32'(m_busy[i]));
        chk($sformatf("d%0d_wr", i),          32'(wr), 32'(m_wr[i]));
        chk($sformatf("d%0d_done", i),        32'(dn), 32'(m_done[i]));
        chk($sformatf("d%0d_error", i),       32'(er), 32'(m_err[i]));
        chk($sformatf("d%0d_addr", i),        ad,      32'(m_addr[i]));
        chk($sformatf("d%0d_data", i),        da,      m_word[i]);
        chk($sformatf("d%0d_count", i),       cn,      32'(m_count[i]));
    endfunction

    always @(negedge clk) begin
        cmp_dut(0, bus0.loadProgram, bus0.wr_instruction, bus0.load_done, bus0.load_error,
                bus0.addressInstrucctionProgram, bus0.data_instruction, bus0.instr_count);
        cmp_dut(1, bus1.loadProgram, bus1.wr_instruction, bus1.load_done, bus1.load_error,
                bus1.addressInstrucctionProgram, bus1.data_instruction, bus1.instr_count);
        if (bus0.wr_instruction) begin
            wa0.push_back(bus0.addressInstrucctionProgram);
            wd0.push_back(bus0.data_instruction);
        end
        if (bus1.wr_instruction) wcnt1++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rxd = 1'b1; rxb = b;
        tick();
        rxd = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
    endtask

    task automatic pulse_start();
        st = 1'b1;
        tick();
        st = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; st = 1'b0; rxd = 1'b0; rxb = 8'h00;
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("pin_reset_loadProgram", 32'(bus0.loadProgram), 32'd0);
        chk("pin_reset_done",        32'(bus0.load_done),   32'd0);
        chk("pin_reset_count",       bus0.instr_count,      32'd0);

        // Reset after two bytes discards the partial word.
        pulse_start();
        send(8'h11); send(8'h22);
        rst = 1'b1;
        #1;
        chk("pin_async_reset_loadProgram", 32'(bus0.loadProgram), 32'd0);
        idle(1);
        rst = 1'b0;
        idle(1);
        chk("pin_midload_reset_writes", 32'(wa0.size()), 32'd0);

        // Gapped bytes, with an ignored start_load in the middle.
        pulse_start();
        idle(1);
        send(8'h12); idle(2); send(8'h34); send(8'h56); idle(1);
        pulse_start();
        send(8'h78);
        idle(2);
        chk("pin_first_write_count", 32'(wa0.size()), 32'd1);
        chk("pin_first_write_addr",  wa0[0], 32'd0);
        chk("pin_first_write_data",  wd0[0], 32'h1234_5678);
        chk("pin_model_count_1",     32'(m_count[0]), 32'd1);

        // Two more words then HALT: four writes at addresses 0..3.
        send_word(32'hA1B2_C3D4);
        idle(1);
        send_word(32'h0BAD_F00D);
        send_word(32'hFFFF_FFFF);
        idle(3);
        chk("pin_halt_writes",  32'(wa0.size()), 32'd4);
        chk("pin_halt_addr",    wa0[3], 32'd3);
        chk("pin_halt_data",    wd0[3], 32'hFFFF_FFFF);
        chk("pin_halt_done",    32'(bus0.load_done),   32'd1);
        chk("pin_halt_count",   bus0.instr_count,      32'd4);
        chk("pin_halt_error",   32'(bus0.load_error),  32'd0);
        chk("pin_halt_loadPrg", 32'(bus0.loadProgram), 32'd0);
        chk("pin_d1_halt_error", 32'(bus1.load_error), 32'd0);
        chk("pin_model_done",   32'(m_done[0]), 32'd1);

        // Bytes while DONE produce no write.
        repeat (5) send(8'h5A);
        idle(2);
        chk("pin_done_ignores_rx", 32'(wa0.size()), 32'd4);
        chk("pin_done_holds",      32'(bus0.load_done), 32'd1);

        // Byte AA lands in the write cycle and starts the next word.
        pulse_start();
        send_word(32'h0102_0304);
        send_word(32'hAABB_CCDD);
        send_word(32'h5566_7788);
        send_word(32'h99AA_BBCC);
        idle(2);
        chk("pin_write_cycle_byte_data", wd0[5], 32'hAABB_CCDD);
        chk("pin_write_cycle_byte_addr", wa0[5], 32'd1);
        chk("pin_depth_done",  32'(bus1.load_done),  32'd1);
        chk("pin_depth_error", 32'(bus1.load_error), 32'd1);
        chk("pin_depth_count", bus1.instr_count,     32'd4);
        n = wcnt1;
        send_word(32'h1357_9BDF);
        send_word(32'h2468_ACE0);
        idle(2);
        chk("pin_depth_no_more_writes", 32'(wcnt1), 32'(n));

        // Randomized traffic, HALT-prone bytes, occasional starts and resets.
        for (int c = 0; c < 4000; c++) begin
            rxd = ($urandom_range(0, 2) != 0);
            rxb = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
            st  = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 500) == 0);
            tick();
        end
        rst = 1'b0; st = 1'b0; rxd = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
